// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared definitions for the skid-buffered pipeline stage register:
// state encoding, zero word and default field widths.
package pipe_stage_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

    localparam int CTRL_W_DEF   = 10;
    localparam int DATA_W_DEF   = 32;
    localparam int NUM_DATA_DEF = 3;
    localparam int ADDR_W_DEF   = 5;

endpackage

// File: rtl/pipe_stage_skid_reg_slot.sv
// Payload register for one beat: load enable, zero on reset, and a clear
// that zeroes only the control field (top CTRL_W bits) to form a bubble.
module pipe_slot_reg #(
    parameter int WIDTH  = 8,
    parameter int CTRL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             ctrl_clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] slot_d;
    logic [WIDTH-1:0] slot_q;

    always_comb begin
        slot_d = slot_q;
        if (load) begin
            slot_d = d;
        end else if (ctrl_clr) begin
            slot_d[WIDTH-1 -: CTRL_W] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q = slot_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer
// and synchronous flush. Optional counters enabled by PIPE_STAGE_STATS_EN.
module pipe_stage_skid_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int CTRL_W   = CTRL_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_DATA = NUM_DATA_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          ctrl_in,
    input  logic [NUM_DATA*DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0]          rs_in,
    input  logic [ADDR_W-1:0]          rt_in,
    input  logic [ADDR_W-1:0]          rd_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          ctrl_out,
    output logic [NUM_DATA*DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0]          rs_out,
    output logic [ADDR_W-1:0]          rt_out,
`ifdef PIPE_STAGE_STATS_EN
    output logic [31:0]                stall_cnt,
    output logic [31:0]                bubble_cnt,
`endif
    output logic [ADDR_W-1:0]          rd_out
);

    localparam int PAY_W = CTRL_W + NUM_DATA*DATA_W + 3*ADDR_W;

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             in_xfer, out_xfer;
    logic             main_load, skid_load, main_from_skid;
    logic [PAY_W-1:0] in_pay, main_pay_d, main_q, skid_q;

    assign in_pay     = {ctrl_in, data_in, rs_in, rt_in, rd_in};
    assign out_valid  = (state_q != ST_EMPTY);
    assign in_ready   = in_ready_q;
    assign in_xfer    = in_valid & in_ready_q;
    assign out_xfer   = out_valid & out_ready;
    assign main_pay_d = main_from_skid ? skid_q : in_pay;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_load = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end else if (in_xfer) begin
                    skid_load = 1'b1;
                    state_d   = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush drops held beats and any beat accepted this cycle; main keeps
        // its data while the slot clears the control field.
        if (flush) begin
            state_d   = ST_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_slot_reg #(.WIDTH(PAY_W), .CTRL_W(CTRL_W)) u_main (
        .clk      (clk),
        .rst      (rst),
        .load     (main_load),
        .ctrl_clr (flush),
        .d        (main_pay_d),
        .q        (main_q)
    );

    pipe_slot_reg #(.WIDTH(PAY_W), .CTRL_W(CTRL_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .ctrl_clr (1'b0),
        .d        (in_pay),
        .q        (skid_q)
    );

    assign {ctrl_out, data_out, rs_out, rt_out, rd_out} = main_q;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !out_ready) begin
            stall_cnt_d = sat_inc32(stall_cnt_q);
        end
        if (flush && (out_valid || in_xfer)) begin
            bubble_cnt_d = sat_inc32(bubble_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= WORD_ZERO;
            bubble_cnt_q <= WORD_ZERO;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
